// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGIT:0]   slice;
    logic             last;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs come from registered state only, so no input reaches them combinationally.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        last  = (cnt_q == CNT_W'(N - 1));
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                // New digit enters at the MSB end so the result is aligned after N shifts.
                res_d   = res_q >> DIGIT;
                res_d[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
                if (last) begin
                    sum_d  = res_d;
                    cout_d = slice[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub: an 8-bit/1-digit and a 16-bit/4-digit instance.
module tb_serial_add_sub;
    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf8, ovf16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input bit wide);
        return wide ? out_valid16 : out_valid8;
    endfunction

    function automatic logic get_ready(input bit wide);
        return wide ? in_ready16 : in_ready8;
    endfunction

    // Issues one operation, waits for its result and leaves the DUT holding it in DONE.
    task automatic run_op(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic s, output logic [15:0] exp_sum);
        int w, n, lat;
        longint unsigned mask, ua, ub, full;
        longint sa, sb, sr, lim;
        logic exp_cout, exp_ovf;
        w    = wide ? 16 : 8;
        n    = wide ? 4 : 8;
        mask = (64'd1 << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        if (s) begin
            exp_sum  = 16'((ua - ub) & mask);
            exp_cout = (ua >= ub);
        end else begin
            full     = ua + ub + longint'(ci);
            exp_sum  = 16'(full & mask);
            exp_cout = full[w];
        end
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa -= (longint'(1) << w);
        if (ub[w-1]) sb -= (longint'(1) << w);
        sr  = s ? (sa - sb) : (sa + sb + longint'(ci));
        lim = longint'(1) << (w - 1);
        exp_ovf = (sr >= lim) || (sr < -lim);

        @(negedge clk);
        check_output("in_ready_before_op", 32'(get_ready(wide)), 32'd1);
        if (wide) begin
            in_valid16 = 1'b1; a16 = av; b16 = bv; cin16 = ci; sub16 = s;
        end else begin
            in_valid8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; sub8 = s;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble operands after the accepting edge: the block must use its own copies.
        if (wide) begin
            in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); sub16 = 1'($urandom);
        end else begin
            in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
        end
        lat = 0;
        while (!get_valid(wide) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_output("latency", 32'(lat), 32'(n));
        if (wide) begin
            check_output("sum16", 32'(sum16), 32'(exp_sum));
            check_output("cout16", 32'(cout16), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
            check_output("ovf16", 32'(ovf16), 32'(exp_ovf));
`endif
        end else begin
            check_output("sum8", 32'(sum8), 32'(exp_sum));
            check_output("cout8", 32'(cout8), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
            check_output("ovf8", 32'(ovf8), 32'(exp_ovf));
`endif
        end
    endtask

    task automatic release_result(input bit wide);
        if (wide) out_ready16 = 1'b1; else out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (wide) out_ready16 = 1'b0; else out_ready8 = 1'b0;
        check_output("out_valid_after_release", 32'(get_valid(wide)), 32'd0);
        check_output("in_ready_after_release", 32'(get_ready(wide)), 32'd1);
    endtask

    initial begin
        logic [15:0] es;
        logic [15:0] ra, rb;
        logic        rc, rs;

        rst_n = 1'b0;
        in_valid8 = 1'b0;  a8 = '0;  b8 = '0;  cin8 = 1'b0;  sub8 = 1'b0;  out_ready8 = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_in_ready", 32'(in_ready8), 32'd1);
        check_output("reset_out_valid", 32'(out_valid8), 32'd0);
        check_output("reset_sum", 32'(sum8), 32'd0);
        check_output("reset_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;

        $display("[TB] add with backpressure");
        run_op(1'b0, 16'h3C, 16'h0F, 1'b1, 1'b0, es);
        check_output("add_3c_0f_sum", 32'(sum8), 32'h4C);
        // Hold the result while a new operand bundle is offered; it must be ignored.
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_out_valid", 32'(out_valid8), 32'd1);
            check_output("bp_in_ready", 32'(in_ready8), 32'd0);
            check_output("bp_sum", 32'(sum8), 32'h4C);
        end
        in_valid8 = 1'b0;
        release_result(1'b0);
        check_output("idle_sum_held", 32'(sum8), 32'h4C);

        run_op(1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, es);
        check_output("add_ff_01_sum", 32'(sum8), 32'h00);
        check_output("add_ff_01_cout", 32'(cout8), 32'd1);
        release_result(1'b0);

        $display("[TB] subtract");
        run_op(1'b0, 16'h05, 16'h07, 1'b1, 1'b1, es);
        check_output("sub_05_07_sum", 32'(sum8), 32'hFE);
        check_output("sub_05_07_cout", 32'(cout8), 32'd0);
        release_result(1'b0);
        run_op(1'b0, 16'h07, 16'h05, 1'b0, 1'b1, es);
        check_output("sub_07_05_sum", 32'(sum8), 32'h02);
        check_output("sub_07_05_cout", 32'(cout8), 32'd1);
        release_result(1'b0);

`ifdef SERIAL_ADD_OVF_EN
        $display("[TB] overflow");
        run_op(1'b0, 16'h7F, 16'h01, 1'b0, 1'b0, es);
        check_output("ovf_7f_01", 32'(ovf8), 32'd1);
        release_result(1'b0);
        run_op(1'b0, 16'h80, 16'h01, 1'b0, 1'b1, es);
        check_output("ovf_80_01_sum", 32'(sum8), 32'h7F);
        check_output("ovf_80_01", 32'(ovf8), 32'd1);
        release_result(1'b0);
        run_op(1'b0, 16'h10, 16'h20, 1'b0, 1'b0, es);
        check_output("ovf_10_20", 32'(ovf8), 32'd0);
        release_result(1'b0);
`endif

        $display("[TB] reset mid-operation");
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midrst_in_ready", 32'(in_ready8), 32'd1);
        check_output("midrst_out_valid", 32'(out_valid8), 32'd0);
        check_output("midrst_sum", 32'(sum8), 32'd0);
        check_output("midrst_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("post_rst_no_valid", 32'(out_valid8), 32'd0);
        end

        $display("[TB] random 16-bit / 4-digit ops");
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_op(1'b1, ra, rb, rc, rs, es);
            release_result(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
